// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the RISC-V core's commit-side logic.
//   HALT_INST0 / HALT_INST1 : the two instructions that, when they retire in
//                             order, terminate the program
//                             (addi ra,x0,12 followed by jalr x0,0(ra)).
//   halt_state_e            : state of the termination-sequence detector.
package riscv_pkg;

    localparam logic [31:0] HALT_INST0 = 32'h00c00093;
    localparam logic [31:0] HALT_INST1 = 32'h00008067;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ARMED  = 2'd1,
        HALTED = 2'd2
    } halt_state_e;

endpackage

// File: rtl/riscv_halt_detect.sv
// riscv_halt_detect
//   Watches the retirement stream for the termination pair HALT_INST0 then
//   HALT_INST1. Bubbles between the pair are tolerated, and any other
//   retirement in between cancels the sequence. Once the pair is seen the
//   detector stays halted until reset.
// Ports
//   CLK        in   core clock
//   RSTn       in   synchronous active-low reset
//   RET_VALID  in   an instruction retires this cycle
//   RET_INST   in   encoding of the retiring instruction
//   halted     out  registered; high from the edge that retires HALT_INST1
module riscv_halt_detect
    import riscv_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              RET_VALID,
    input  logic [DWIDTH-1:0] RET_INST,
    output logic              halted
);

    halt_state_e state;
    halt_state_e next_state;

    logic is_inst0;
    logic is_inst1;

    assign is_inst0 = (RET_INST == DWIDTH'(HALT_INST0));
    assign is_inst1 = (RET_INST == DWIDTH'(HALT_INST1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            state  <= next_state;
            // Register the decode so HALT comes straight from a flop.
            halted <= (next_state == HALTED);
        end
    end

    always_comb begin
        // NOTE: default assigned first so no branch leaves next_state
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        case (state)
            RUN: begin
                if (RET_VALID && is_inst0) begin
                    next_state = ARMED;
                end
            end
            ARMED: begin
                if (RET_VALID) begin
                    if (is_inst1) begin
                        next_state = HALTED;
                    end else if (is_inst0) begin
                        next_state = ARMED;
                    end else begin
                        next_state = RUN;
                    end
                end
            end
            HALTED: begin
                next_state = HALTED;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

endmodule

// File: rtl/riscv_retire_monitor.sv
// riscv_retire_monitor
//   Commit-side monitor: counts retired instructions, latches a result word
//   per retirement and raises HALT once the termination sequence retires.
//   After HALT every output is frozen until reset.
// Ports
//   CLK, RSTn     core clock, synchronous active-low reset
//   RET_VALID     one instruction retires this cycle
//   RET_INST      retiring instruction encoding
//   RET_WB_EN     retiring instruction writes a non-x0 register
//   RET_WB_DATA   value written to rd
//   RET_STORE     retiring instruction is a store
//   RET_ADDR      store effective byte address
//   RET_BRANCH    retiring instruction is a conditional branch
//   RET_TAKEN     branch outcome
//   NUM_INST      retired-instruction count (wraps silently)
//   OUTPUT_PORT   result word of the latest qualifying retirement
//   HALT          program terminated, held until reset
//   NUM_CYCLE     cycle count while not halted (only with RETIRE_CYCLE_CNT_EN)
// Configuration
//   RETIRE_CYCLE_CNT_EN  define to add the NUM_CYCLE port and counter.
module riscv_retire_monitor
    import riscv_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 RET_VALID,
    input  logic [DWIDTH-1:0]    RET_INST,
    input  logic                 RET_WB_EN,
    input  logic [DWIDTH-1:0]    RET_WB_DATA,
    input  logic                 RET_STORE,
    input  logic [DWIDTH-1:0]    RET_ADDR,
    input  logic                 RET_BRANCH,
    input  logic                 RET_TAKEN,
    output logic [CNT_WIDTH-1:0] NUM_INST,
    output logic [DWIDTH-1:0]    OUTPUT_PORT,
    output logic                 HALT
`ifdef RETIRE_CYCLE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] NUM_CYCLE
`endif
);

    logic              halted;
    logic              retire;
    logic [DWIDTH-1:0] out_next;

    riscv_halt_detect #(
        .DWIDTH (DWIDTH)
    ) u_halt_detect (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .RET_VALID (RET_VALID),
        .RET_INST  (RET_INST),
        .halted    (halted)
    );

    // halted is registered, so the halting jalr itself still counts: it is
    // sampled on the same edge that first sets halted.
    assign retire = RET_VALID && !halted;
    assign HALT   = halted;

    // Result word priority: store address, then branch outcome, then
    // register write data; otherwise keep the previous word.
    always_comb begin
        out_next = OUTPUT_PORT;
        if (RET_STORE) begin
            out_next = RET_ADDR;
        end else if (RET_BRANCH) begin
            out_next = DWIDTH'(RET_TAKEN);
        end else if (RET_WB_EN) begin
            out_next = RET_WB_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            NUM_INST    <= '0;
            OUTPUT_PORT <= '0;
        end else if (retire) begin
            NUM_INST    <= NUM_INST + 1'b1;
            OUTPUT_PORT <= out_next;
        end
    end

`ifdef RETIRE_CYCLE_CNT_EN
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            NUM_CYCLE <= '0;
        end else if (!halted) begin
            NUM_CYCLE <= NUM_CYCLE + 1'b1;
        end
    end
`endif

endmodule

// File: doc/riscv_retire_monitor.md
# riscv_retire_monitor

Commit-side monitor for the RISC-V core: consumes one retirement event per cycle from the write-back stage and produces the architectural observation signals NUM_INST, OUTPUT_PORT and HALT exported by RISCV_TOP. It counts retired instructions and latches a per-instruction result word. It also detects the program-termination sequence and then freezes all outputs until reset.

## Interface
- DWIDTH, 32, width of data, address and instruction buses
- CNT_WIDTH, 32, width of NUM_INST (and NUM_CYCLE when configured)
- CLK  in  1  core clock; all state updates on rising edge
- RSTn  in  1  synchronous, active-low reset, sampled on CLK rising edge
- RET_VALID  in  1  one instruction retires this cycle (bubbles/flushed slots deassert it)
- RET_INST  in  DWIDTH  raw encoding of the retiring instruction
- RET_WB_EN  in  1  retiring instruction writes a register other than x0
- RET_WB_DATA  in  DWIDTH  value written to rd
- RET_STORE  in  1  retiring instruction is a store
- RET_ADDR  in  DWIDTH  effective byte address of the store
- RET_BRANCH  in  1  retiring instruction is a conditional branch
- RET_TAKEN  in  1  branch outcome (valid when RET_BRANCH)
- NUM_INST  out  CNT_WIDTH  count of retired instructions
- OUTPUT_PORT  out  DWIDTH  result word of the most recent qualifying retirement
- HALT  out  1  program terminated; level, held until reset

## Operation
- FSM states: RUN, ARMED, HALTED. Reset state RUN.
- RUN: retire of 0x00c00093 (addi ra,x0,12) -> ARMED; anything else stays RUN.
- ARMED: retire of 0x00008067 (jalr x0,0(ra)) -> HALTED; retire of 0x00c00093 -> ARMED; any other retire -> RUN; no retire (RET_VALID=0) -> stay ARMED (bubbles between the pair are allowed).
- HALTED: absorbing; all RET_* inputs ignored; NUM_INST, OUTPUT_PORT, HALT frozen.
- NUM_INST: +1 on every RET_VALID cycle not in HALTED, including the halting jalr. Wraps modulo 2^CNT_WIDTH without flag.
- OUTPUT_PORT update priority on a retire (not HALTED): RET_STORE -> RET_ADDR; else RET_BRANCH -> zero-extended RET_TAKEN (0x0 or 0x1); else RET_WB_EN -> RET_WB_DATA; else hold previous value.
- Malformed input with several of STORE/BRANCH/WB_EN set follows the priority above; no error raised.
- HALT asserts high in the state HALTED.

## Timing
- All outputs registered. Reset values: NUM_INST=0, OUTPUT_PORT=0, HALT=0, NUM_CYCLE=0.
- Latency 1: retire sampled at edge N -> NUM_INST and OUTPUT_PORT reflect it after edge N, same cycle together (a consumer sampling both on edge N+1 sees a consistent pair).
- HALT rises after the same edge that counts the jalr; NUM_INST at HALT already includes it.
- RSTn low at any edge, including mid-sequence in ARMED or in HALTED: all state returns to reset values on that edge; RSTn dominates RET_VALID.
- No backpressure: monitor accepts one retire every cycle.

## Configuration
- RETIRE_CYCLE_CNT_EN defined: extra port NUM_CYCLE  out  CNT_WIDTH; increments every cycle with RSTn high and state not HALTED; frozen after HALT; reset 0.
- Undefined: port and counter absent; remaining behaviour identical.

## Structure
- Shared package riscv_pkg: constants HALT_INST0=32'h00c00093, HALT_INST1=32'h00008067; FSM state enum (RUN, ARMED, HALTED).
- One sub-module riscv_halt_detect: FSM only (inputs CLK, RSTn, RET_VALID, RET_INST; output halted). Counter and output-port mux live in riscv_retire_monitor.

## Test plan
- Reset then three WB retires with data 5, 0, 1 -> NUM_INST 1,2,3 and OUTPUT_PORT 0x5,0x0,0x1 on consecutive cycles; HALT=0.
- Store to 0x40 then taken branch then retire with RET_WB_EN=0 -> OUTPUT_PORT 0x40, 0x1, 0x1 (held); NUM_INST +3.
- 0x00c00093, two bubbles, 0x00008067 -> HALT=1 one edge after jalr retire, NUM_INST=2; further retires leave NUM_INST, OUTPUT_PORT unchanged.
- 0x00c00093, addi other, 0x00008067 -> FSM back to RUN; HALT stays 0, NUM_INST=3.
- RSTn low for one edge while ARMED, then 0x00008067 -> no HALT, NUM_INST=1; also RSTn low while HALTED -> all outputs 0.
- With RETIRE_CYCLE_CNT_EN: 10 cycles run, halt sequence retires at cycle 10 -> NUM_CYCLE frozen at 10.
